async_fifo_rptr_empty: RTL and testbench

Read-domain pointer and status controller for the async FIFO. It takes the write pointer after the 2-flop synchronizer has brought it into the read clock domain as Gray code. From that it advances the read pointer on accepted reads, drives the RAM read address, and produces the empty, almost-empty, level and underflow status. Its Gray read pointer is the value that the write domain synchronizes to build its full flag.

---
 rtl/async_fifo_rptr_empty.sv | 78 +++++++
 tb/tb_async_fifo_rptr_empty.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rptr_empty.sv
// Read-domain pointer/status controller for the async FIFO: read pointer, RAM address, empty/level/underflow.
// Optional: define ASYNC_FIFO_UNDERFLOW_STICKY_EN to hold o_underflow high from the first underflow until reset.
module async_fifo_rptr_empty #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH:0]   i_wptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic [ADDR_WIDTH:0]   o_rptr_gray,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_rd_level,
  output logic                  o_underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] wbin_sync;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          underflow_q, underflow_d;
  logic          rd_fire;

  // Next pointer, status and level from the synchronized write pointer
  always_comb begin
    rd_fire = i_rd_en & ~empty_q;
    rbin_d  = rbin_q + PW'(rd_fire);
    rgray_d = (rbin_d >> 1) ^ rbin_d;

    wbin_sync         = '0;
    wbin_sync[PW-1]   = i_wptr_gray_sync[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      wbin_sync[i] = wbin_sync[i+1] ^ i_wptr_gray_sync[i];
    end

    level_d  = wbin_sync - rbin_d;
    empty_d  = (rgray_d == i_wptr_gray_sync);
    aempty_d = (level_d <= AE_T);
`ifdef ASYNC_FIFO_UNDERFLOW_STICKY_EN
    underflow_d = underflow_q | (i_rd_en & empty_q);
`else
    underflow_d = i_rd_en & empty_q;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_raddr        = rbin_q[ADDR_WIDTH-1:0];
  assign o_rptr_gray    = rgray_q;
  assign o_empty        = empty_q;
  assign o_almost_empty = aempty_q;
  assign o_rd_level     = level_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_async_fifo_rptr_empty.sv
// Directed self-checking bench for async_fifo_rptr_empty (ADDR_WIDTH=3, AE_THRESH=1).
module tb_async_fifo_rptr_empty;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_rd_en;
  logic [3:0] i_wptr_gray_sync;
  logic [2:0] o_raddr;
  logic [3:0] o_rptr_gray;
  logic       o_empty;
  logic       o_almost_empty;
  logic [3:0] o_rd_level;
  logic       o_underflow;

  int n_checks = 0;
  int n_fail   = 0;
  int wb, rb;

`ifdef ASYNC_FIFO_UNDERFLOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  async_fifo_rptr_empty #(.ADDR_WIDTH(3), .AE_THRESH(1)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_rd_en          (i_rd_en),
    .i_wptr_gray_sync (i_wptr_gray_sync),
    .o_raddr          (o_raddr),
    .o_rptr_gray      (o_rptr_gray),
    .o_empty          (o_empty),
    .o_almost_empty   (o_almost_empty),
    .o_rd_level       (o_rd_level),
    .o_underflow      (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_empty"},  32'(o_empty),        32'd1);
    check_eq({tag, "_ae"},     32'(o_almost_empty), 32'd1);
    check_eq({tag, "_level"},  32'(o_rd_level),     32'd0);
    check_eq({tag, "_gray"},   32'(o_rptr_gray),    32'd0);
    check_eq({tag, "_raddr"},  32'(o_raddr),        32'd0);
    check_eq({tag, "_uflow"},  32'(o_underflow),    32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    i_rd_en = 1'b0;
    i_wptr_gray_sync = 4'b0000;
    wb = 0;
    rb = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    // Three words become visible, then drained one per cycle
    i_wptr_gray_sync = 4'b0010;
    wb = 3;
    @(negedge clk);
    check_eq("vis_empty", 32'(o_empty),        32'd0);
    check_eq("vis_level", 32'(o_rd_level),     32'd3);
    check_eq("vis_ae",    32'(o_almost_empty), 32'd0);
    i_rd_en = 1'b1;
    @(negedge clk);
    check_eq("rd1_raddr", 32'(o_raddr),        32'd1);
    check_eq("rd1_gray",  32'(o_rptr_gray),    32'b0001);
    check_eq("rd1_ae",    32'(o_almost_empty), 32'd0);
    check_eq("rd1_empty", 32'(o_empty),        32'd0);
    @(negedge clk);
    check_eq("rd2_raddr", 32'(o_raddr),        32'd2);
    check_eq("rd2_gray",  32'(o_rptr_gray),    32'b0011);
    check_eq("rd2_ae",    32'(o_almost_empty), 32'd1);
    check_eq("rd2_empty", 32'(o_empty),        32'd0);
    check_eq("rd2_level", 32'(o_rd_level),     32'd1);
    @(negedge clk);
    check_eq("rd3_raddr", 32'(o_raddr),        32'd3);
    check_eq("rd3_gray",  32'(o_rptr_gray),    32'b0010);
    check_eq("rd3_empty", 32'(o_empty),        32'd1);
    check_eq("rd3_level", 32'(o_rd_level),     32'd0);
    check_eq("rd3_uflow", 32'(o_underflow),    32'd0);
    rb = 3;

    // Two back-to-back reads while empty
    @(negedge clk);
    check_eq("uf1_pulse", 32'(o_underflow), 32'd1);
    check_eq("uf1_raddr", 32'(o_raddr),     32'd3);
    check_eq("uf1_gray",  32'(o_rptr_gray), 32'b0010);
    @(negedge clk);
    check_eq("uf2_pulse", 32'(o_underflow), 32'd1);
    check_eq("uf2_gray",  32'(o_rptr_gray), 32'b0010);
    i_rd_en = 1'b0;
    @(negedge clk);
    check_eq("uf_after",  32'(o_underflow), 32'(STICKY));
    check_eq("uf_level",  32'(o_rd_level),  32'd0);

    // Four rounds of fill-5 / drain-5 carry the pointer across 15 -> 0
    for (int r = 0; r < 4; r++) begin
      for (int j = 1; j <= 5; j++) begin
        wb++;
        i_wptr_gray_sync = to_gray(wb);
        @(negedge clk);
        check_eq($sformatf("fill%0d_%0d_level", r, j), 32'(o_rd_level),     32'(j));
        check_eq($sformatf("fill%0d_%0d_empty", r, j), 32'(o_empty),        32'd0);
        check_eq($sformatf("fill%0d_%0d_ae", r, j),    32'(o_almost_empty), 32'(j <= 1));
      end
      for (int j = 1; j <= 5; j++) begin
        i_rd_en = 1'b1;
        @(negedge clk);
        rb++;
        check_eq($sformatf("drain%0d_%0d_raddr", r, j), 32'(o_raddr),     32'(rb % 8));
        check_eq($sformatf("drain%0d_%0d_gray", r, j),  32'(o_rptr_gray), 32'(to_gray(rb % 16)));
        check_eq($sformatf("drain%0d_%0d_level", r, j), 32'(o_rd_level),  32'(5 - j));
        check_eq($sformatf("drain%0d_%0d_empty", r, j), 32'(o_empty),     32'(j == 5));
      end
      i_rd_en = 1'b0;
    end

    // Last word read while one new word arrives
    wb++;
    i_wptr_gray_sync = to_gray(wb);
    @(negedge clk);
    check_eq("sim_pre_level", 32'(o_rd_level), 32'd1);
    i_rd_en = 1'b1;
    wb++;
    i_wptr_gray_sync = to_gray(wb);
    @(negedge clk);
    i_rd_en = 1'b0;
    rb++;
    check_eq("sim_empty", 32'(o_empty),     32'd0);
    check_eq("sim_level", 32'(o_rd_level),  32'd1);
    check_eq("sim_raddr", 32'(o_raddr),     32'd0);
    check_eq("sim_gray",  32'(o_rptr_gray), 32'b1100);

    // Asynchronous reset while draining with level 5
    wb = rb + 6;
    i_wptr_gray_sync = to_gray(wb);
    @(negedge clk);
    check_eq("pre_rst_level6", 32'(o_rd_level), 32'd6);
    i_rd_en = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_level5", 32'(o_rd_level), 32'd5);
    check_eq("pre_rst_raddr",  32'(o_raddr),    32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("async_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
